// File: rtl/bp_mem_cmd_arb.sv
// Two-requester memory command arbiter (proc = 0, loader = 1) with round-robin grant.
// Responses are steered back in order using a FIFO of requester IDs.
package bp_mem_cmd_arb_pkg;
  typedef enum logic [1:0] {
    e_bp_softcore_cfg,
    e_bp_unicore_cfg,
    e_bp_multicore_1_cfg
  } bp_params_e;

  function automatic int mem_msg_width(bp_params_e cfg);
    case (cfg)
      e_bp_softcore_cfg: return 128;
      default:           return 576;
    endcase
  endfunction
endpackage

module bp_mem_cmd_arb
  import bp_mem_cmd_arb_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_softcore_cfg,
  parameter int max_outstanding_p = 4,
  localparam int cce_mem_msg_width_lp = mem_msg_width(bp_params_p),
  localparam int cnt_width_lp = $clog2(max_outstanding_p + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [1:0][cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic [1:0]                           mem_cmd_v_i,
  output logic [1:0]                           mem_cmd_ready_o,
  output logic [1:0][cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic [1:0]                           mem_resp_v_o,
  input  logic [1:0]                           mem_resp_yumi_i,
  output logic [cce_mem_msg_width_lp-1:0]      mem_cmd_o,
  output logic                                 mem_cmd_v_o,
  input  logic                                 mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0]      mem_resp_i,
  input  logic                                 mem_resp_v_i,
  output logic                                 mem_resp_yumi_o,
  output logic [cnt_width_lp-1:0]              outstanding_o
);

  localparam int ptr_width_lp = $clog2(max_outstanding_p);

  logic                         last_winner_r;
  logic                         winner;
  logic [1:0]                   grant;
  logic                         full, empty, push, pop, head, resp_active;
  logic [ptr_width_lp-1:0]      rptr_r, wptr_r;
  logic [cnt_width_lp-1:0]      count_r;
  logic [max_outstanding_p-1:0] tag_r;

  assign full  = (count_r == cnt_width_lp'(max_outstanding_p));
  assign empty = (count_r == '0);

  // On a tie the requester that did not win last goes; otherwise the lone valid one.
  assign winner = (&mem_cmd_v_i) ? ~last_winner_r : mem_cmd_v_i[1];
  assign grant  = mem_cmd_v_i & (winner ? 2'b10 : 2'b01);

  assign mem_cmd_v_o     = (|mem_cmd_v_i) & ~full & ~reset_i;
  assign mem_cmd_ready_o = grant & {2{mem_cmd_ready_i & ~full & ~reset_i}};
  assign mem_cmd_o       = mem_cmd_i[winner];
  assign push            = mem_cmd_v_o & mem_cmd_ready_i;

  assign head        = tag_r[rptr_r];
  assign resp_active = ~empty & ~reset_i;

  always_comb begin
    mem_resp_v_o       = 2'b00;
    mem_resp_v_o[head] = mem_resp_v_i & resp_active;
  end

  assign mem_resp_o      = {mem_resp_i, mem_resp_i};
  assign mem_resp_yumi_o = resp_active & mem_resp_yumi_i[head];
  assign pop             = mem_resp_yumi_o;
  assign outstanding_o   = count_r;

  // Full blocks issue outright, so push and pop never race on the last slot.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_winner_r <= 1'b1;
      rptr_r        <= '0;
      wptr_r        <= '0;
      count_r       <= '0;
    end else begin
      if (push) begin
        wptr_r        <= wptr_r + ptr_width_lp'(1);
        last_winner_r <= winner;
      end
      if (pop) rptr_r <= rptr_r + ptr_width_lp'(1);
      count_r <= count_r + cnt_width_lp'(push) - cnt_width_lp'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) tag_r[wptr_r] <= winner;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(mem_resp_v_i && empty))
        else $error("bp_mem_cmd_arb: memory response with no command in flight");
      assert ((mem_resp_yumi_i & ~mem_resp_v_o) == 2'b00)
        else $error("bp_mem_cmd_arb: requester consumed a response that was not offered");
    end
  end
`endif

endmodule

// File: tb/tb_bp_mem_cmd_arb.sv
// Bench for bp_mem_cmd_arb: directed scenarios plus random traffic checked against
// a queue-based model of grants and in-flight requester IDs.
module tb_bp_mem_cmd_arb;
  import bp_mem_cmd_arb_pkg::*;

  localparam bp_params_e CFG = e_bp_softcore_cfg;
  localparam int W   = mem_msg_width(CFG);
  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX + 1);

  logic              clk = 1'b0;
  logic              reset_i;
  logic [1:0][W-1:0] mem_cmd_i;
  logic [1:0]        mem_cmd_v_i;
  logic [1:0]        mem_cmd_ready_o;
  logic [1:0][W-1:0] mem_resp_o;
  logic [1:0]        mem_resp_v_o;
  logic [1:0]        mem_resp_yumi_i;
  logic [W-1:0]      mem_cmd_o;
  logic              mem_cmd_v_o;
  logic              mem_cmd_ready_i;
  logic [W-1:0]      mem_resp_i;
  logic              mem_resp_v_i;
  logic              mem_resp_yumi_o;
  logic [CW-1:0]     outstanding_o;

  bp_mem_cmd_arb #(.bp_params_p(CFG), .max_outstanding_p(MAX)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_ready_o(mem_cmd_ready_o),
    .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_yumi_i(mem_resp_yumi_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who won last, and the requester IDs still awaiting a response.
  bit last_w = 1'b1;
  bit tagq[$];

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d = '0;
    for (int i = 0; i < W / 32; i++) d = {d[W-33:0], $urandom};
    return d;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already applied; check outputs against the model, clock once, advance the model.
  task automatic step();
    bit full, empty, exp_cmd_v, w, exp_yumi, do_push, hd;
    logic [1:0] exp_ready, exp_resp_v;
    #1;
    full  = (tagq.size() == MAX);
    empty = (tagq.size() == 0);
    hd    = empty ? 1'b0 : tagq[0];
    if (mem_cmd_v_i == 2'b11) w = ~last_w;
    else                      w = mem_cmd_v_i[1];
    exp_cmd_v  = (mem_cmd_v_i != 2'b00) && !full && !reset_i;
    exp_ready  = (exp_cmd_v && mem_cmd_ready_i) ? (2'b01 << w) : 2'b00;
    exp_resp_v = (!empty && !reset_i && mem_resp_v_i) ? (2'b01 << hd) : 2'b00;
    exp_yumi   = !empty && !reset_i && mem_resp_yumi_i[hd];
    do_push    = exp_cmd_v && mem_cmd_ready_i;
    check("cmd_v", W'(mem_cmd_v_o), W'(exp_cmd_v));
    check("cmd_ready", W'(mem_cmd_ready_o), W'(exp_ready));
    if (exp_cmd_v) check("cmd_data", mem_cmd_o, mem_cmd_i[w]);
    check("resp_v", W'(mem_resp_v_o), W'(exp_resp_v));
    check("resp_yumi", W'(mem_resp_yumi_o), W'(exp_yumi));
    check("resp_data0", mem_resp_o[0], mem_resp_i);
    check("resp_data1", mem_resp_o[1], mem_resp_i);
    check("outstanding", W'(outstanding_o), W'(tagq.size()));
    @(posedge clk);
    if (reset_i) begin
      tagq.delete();
      last_w = 1'b1;
    end else begin
      if (exp_yumi) void'(tagq.pop_front());
      if (do_push) begin
        tagq.push_back(w);
        last_w = w;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    mem_cmd_v_i = 2'b00;
    while (tagq.size() > 0 && n < 16) begin
      mem_resp_v_i    = 1'b1;
      mem_resp_i      = rand_data();
      mem_resp_yumi_i = 2'b01 << tagq[0];
      step();
      n++;
    end
    mem_resp_v_i    = 1'b0;
    mem_resp_yumi_i = 2'b00;
    check("drain_empty", W'(outstanding_o), W'(0));
  endtask

  initial begin
    reset_i         = 1'b1;
    mem_cmd_i       = {rand_data(), rand_data()};
    mem_cmd_v_i     = 2'b11;
    mem_cmd_ready_i = 1'b1;
    mem_resp_i      = rand_data();
    mem_resp_v_i    = 1'b0;
    mem_resp_yumi_i = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state with requesters pushing: nothing may be issued.
    step();
    step();
    reset_i = 1'b0;

    // Tie for four cycles alternates 0,1,0,1; responses come back tagged in that order.
    mem_cmd_v_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      mem_cmd_i = {rand_data(), rand_data()};
      #1 check("rr_grant", W'(mem_cmd_ready_o), W'((i % 2 == 0) ? 2'b01 : 2'b10));
      step();
    end
    check("rr_outstanding", W'(outstanding_o), W'(4));
    mem_cmd_v_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      mem_resp_v_i    = 1'b1;
      mem_resp_i      = rand_data();
      mem_resp_yumi_i = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1 check("rr_route", W'(mem_resp_v_o), W'(mem_resp_yumi_i));
      step();
    end
    mem_resp_v_i    = 1'b0;
    mem_resp_yumi_i = 2'b00;

    // Full with a pop in the same cycle still blocks issue; issue resumes next cycle.
    mem_cmd_v_i = 2'b11;
    repeat (4) step();
    check("full_count", W'(outstanding_o), W'(4));
    mem_cmd_v_i     = 2'b01;
    mem_resp_v_i    = 1'b1;
    mem_resp_yumi_i = 2'b01;
    #1 check("full_no_issue", W'(mem_cmd_v_o), W'(0));
    step();
    check("full_pop_count", W'(outstanding_o), W'(3));
    mem_resp_v_i    = 1'b0;
    mem_resp_yumi_i = 2'b00;
    #1 check("full_reissue", W'(mem_cmd_v_o), W'(1));
    step();
    check("full_refill", W'(outstanding_o), W'(4));
    drain();

    // Lone requester 1 wins three times; then a tie goes to requester 0.
    mem_cmd_v_i = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1 check("lone_grant", W'(mem_cmd_ready_o), W'(2'b10));
      step();
    end
    mem_cmd_v_i = 2'b11;
    #1 check("lone_then_tie", W'(mem_cmd_ready_o), W'(2'b01));
    step();
    drain();

    // Stall: after requester 0 wins, a held tie keeps requester 1's command on the bus.
    mem_cmd_v_i = 2'b01;
    step();
    mem_cmd_v_i     = 2'b11;
    mem_cmd_i       = {rand_data(), rand_data()};
    mem_cmd_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check("stall_cmd", mem_cmd_o, mem_cmd_i[1]);
      check("stall_ready", W'(mem_cmd_ready_o), W'(2'b00));
      step();
    end
    mem_cmd_ready_i = 1'b1;
    #1 check("stall_accept", W'(mem_cmd_ready_o), W'(2'b10));
    step();
    drain();

    // Tags 1,0 in flight; head response held without consume, then routed in order.
    mem_cmd_v_i = 2'b10;
    step();
    mem_cmd_v_i = 2'b01;
    step();
    mem_cmd_v_i     = 2'b00;
    mem_resp_v_i    = 1'b1;
    mem_resp_yumi_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_route", W'(mem_resp_v_o), W'(2'b10));
      check("hold_count", W'(outstanding_o), W'(2));
      step();
    end
    mem_resp_yumi_i = 2'b10;
    step();
    mem_resp_yumi_i = 2'b01;
    #1 check("hold_next", W'(mem_resp_v_o), W'(2'b01));
    step();
    mem_resp_v_i    = 1'b0;
    mem_resp_yumi_i = 2'b00;
    check("hold_empty", W'(outstanding_o), W'(0));

    // Reset with three in flight discards them; next tie goes to requester 0.
    mem_cmd_v_i = 2'b11;
    repeat (3) step();
    check("rst_pre", W'(outstanding_o), W'(3));
    reset_i = 1'b1;
    step();
    reset_i     = 1'b0;
    mem_cmd_v_i = 2'b00;
    #1 check("rst_count", W'(outstanding_o), W'(0));
    check("rst_resp_v", W'(mem_resp_v_o), W'(0));
    mem_cmd_v_i = 2'b11;
    #1 check("rst_tie", W'(mem_cmd_ready_o), W'(2'b01));
    step();
    drain();

    // Random traffic obeying the response protocol.
    for (int c = 0; c < 600; c++) begin
      reset_i         = ($urandom_range(0, 59) == 0);
      mem_cmd_v_i     = 2'($urandom);
      mem_cmd_i       = {rand_data(), rand_data()};
      mem_cmd_ready_i = ($urandom_range(0, 3) != 0);
      mem_resp_i      = rand_data();
      if (!reset_i && tagq.size() > 0 && $urandom_range(0, 1) == 1) begin
        mem_resp_v_i    = 1'b1;
        mem_resp_yumi_i = ($urandom_range(0, 2) != 0) ? (2'b01 << tagq[0]) : 2'b00;
      end else begin
        mem_resp_v_i    = 1'b0;
        mem_resp_yumi_i = 2'b00;
      end
      step();
    end
    reset_i = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
